// File: rtl/clock_period_meter_if.sv
// Bundle between a signal source and the period meter.
//   signal_in : measured square wave (asynchronous to the meter clock)
//   period    : last complete period in meter-clock cycles
//   high_time : high cycles within that period
//   valid     : one-cycle pulse when period/high_time update
//   timeout   : level, no rising edge seen for TIMEOUT cycles
//   locked    : level, last two periods agree within tolerance
interface clock_period_meter_if #(
   parameter int unsigned WIDTH = 28
);
   logic             signal_in;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic             valid;
   logic             timeout;
   logic             locked;

   // Source side: drives the signal, observes the results.
   modport master (
      output signal_in,
      input  period,
      input  high_time,
      input  valid,
      input  timeout,
      input  locked
   );

   // Meter side.
   modport slave (
      input  signal_in,
      output period,
      output high_time,
      output valid,
      output timeout,
      output locked
   );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// clock_in cycles, flags loss of signal and period-to-period lock.
//   clock_in : system clock, all logic on rising edge
//   reset_n  : asynchronous active-low reset
//   meter    : clock_period_meter_if.slave (signal_in in, results out)
module clock_period_meter #(
   parameter int unsigned      WIDTH     = 28,
   parameter logic [WIDTH-1:0] TIMEOUT   = WIDTH'(25000000),
   parameter logic [WIDTH-1:0] TOLERANCE = WIDTH'(4)
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   clock_period_meter_if.slave   meter
);

   localparam logic [WIDTH-1:0] TOUT_LAST = TIMEOUT - WIDTH'(1);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_TOUT    = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             rise_c, fall_c, tout_hit_c;
   logic [WIDTH-1:0] diff_c;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hcnt_q, hcnt_d;
   logic [WIDTH-1:0] hcap_q, hcap_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             locked_q, locked_d;
   logic             have_prev_q, have_prev_d;

   // Two-flop synchronizer plus a delay flop for edge detection.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= meter.signal_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_c     = s2_q & ~s3_q;
   assign fall_c     = ~s2_q & s3_q;
   assign tout_hit_c = (cnt_q == TOUT_LAST);
   // Unsigned absolute difference: larger minus smaller.
   assign diff_c     = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);

   // State register.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; a rise always wins over the timeout threshold.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise_c)          state_d = ST_MEASURE;
            else if (tout_hit_c) state_d = ST_TOUT;
         end
         ST_MEASURE: begin
            if (!rise_c && tout_hit_c) state_d = ST_TOUT;
         end
         ST_TOUT: begin
            if (rise_c) state_d = ST_MEASURE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter and result next values.
   always_comb begin
      cnt_d       = cnt_q;
      hcnt_d      = hcnt_q;
      hcap_d      = hcap_q;
      prev_d      = prev_q;
      period_d    = period_q;
      high_d      = high_q;
      valid_d     = 1'b0;
      timeout_d   = timeout_q;
      locked_d    = locked_q;
      have_prev_d = have_prev_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = cnt_q + ONE;
            if (rise_c) begin
               cnt_d       = ONE;
               hcnt_d      = ONE;
               have_prev_d = 1'b0;
            end else if (tout_hit_c) begin
               timeout_d = 1'b1;
               locked_d  = 1'b0;
            end
         end
         ST_MEASURE: begin
            cnt_d = cnt_q + ONE;
            if (s2_q)   hcnt_d = hcnt_q + ONE;
            if (fall_c) hcap_d = hcnt_q;
            if (rise_c) begin
               period_d    = cnt_q;
               high_d      = hcap_q;
               valid_d     = 1'b1;
               prev_d      = cnt_q;
               cnt_d       = ONE;
               hcnt_d      = ONE;
               // Lock needs an earlier period measured since entering MEASURE.
               locked_d    = have_prev_q && (diff_c <= TOLERANCE);
               have_prev_d = 1'b1;
            end else if (tout_hit_c) begin
               timeout_d = 1'b1;
               locked_d  = 1'b0;
            end
         end
         ST_TOUT: begin
            // Counters frozen; first period after recovery is not reported.
            if (rise_c) begin
               cnt_d       = ONE;
               hcnt_d      = ONE;
               timeout_d   = 1'b0;
               have_prev_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         hcnt_q      <= '0;
         hcap_q      <= '0;
         prev_q      <= '0;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
         locked_q    <= 1'b0;
         have_prev_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         hcnt_q      <= hcnt_d;
         hcap_q      <= hcap_d;
         prev_q      <= prev_d;
         period_q    <= period_d;
         high_q      <= high_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
         locked_q    <= locked_d;
         have_prev_q <= have_prev_d;
      end
   end

   assign meter.period    = period_q;
   assign meter.high_time = high_q;
   assign meter.valid     = valid_q;
   assign meter.timeout   = timeout_q;
   assign meter.locked    = locked_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: two instances share one input,
// one with tolerance 4 and one with tolerance 6, both with TIMEOUT=100.
module tb_clock_period_meter;

   localparam int unsigned WIDTH = 28;
   localparam int unsigned TMO   = 100;

   typedef struct {
      int unsigned      cyc;
      logic [WIDTH-1:0] period;
      logic [WIDTH-1:0] high;
      logic             locked;
   } vrec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sig;
   int unsigned cyc = 0;
   int unsigned n_checks;
   int unsigned n_errors;
   int unsigned tset_cyc;
   int unsigned tclr_cyc;
   int unsigned t0;
   logic        tout_prev;
   vrec_t       va_q[$];
   vrec_t       vb_q[$];
   int unsigned rise_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   clock_period_meter_if #(.WIDTH(WIDTH)) if_a ();
   clock_period_meter_if #(.WIDTH(WIDTH)) if_b ();

   assign if_a.signal_in = sig;
   assign if_b.signal_in = sig;

   clock_period_meter #(
      .WIDTH(WIDTH), .TIMEOUT(WIDTH'(TMO)), .TOLERANCE(WIDTH'(4))
   ) u_dut_a (
      .clock_in(clk), .reset_n(rst_n), .meter(if_a.slave)
   );

   clock_period_meter #(
      .WIDTH(WIDTH), .TIMEOUT(WIDTH'(TMO)), .TOLERANCE(WIDTH'(6))
   ) u_dut_b (
      .clock_in(clk), .reset_n(rst_n), .meter(if_b.slave)
   );

   // Record result pulses and timeout edges, sampled mid-cycle.
   always @(negedge clk) begin
      if (if_a.valid) va_q.push_back('{cyc, if_a.period, if_a.high_time, if_a.locked});
      if (if_b.valid) vb_q.push_back('{cyc, if_b.period, if_b.high_time, if_b.locked});
      if (if_a.timeout && !tout_prev) tset_cyc = cyc;
      if (!if_a.timeout && tout_prev) tclr_cyc = cyc;
      tout_prev = if_a.timeout;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // n periods of length p with h high cycles; records each input rise cycle.
   task automatic wave(input int unsigned p, input int unsigned h, input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         sig = 1'b1;
         rise_q.push_back(cyc);
         step(h);
         sig = 1'b0;
         step(p - h);
      end
   endtask

   // Valid j reports period j (p0 for even j, p1 for odd j), appears 3 cycles
   // after input rise j+1, and is locked from index lock_from onward.
   task automatic check_phase(input string tag, input vrec_t q[$],
                              input int unsigned p0, input int unsigned p1,
                              input int unsigned h, input int unsigned nexp,
                              input int unsigned lock_from);
      chk($sformatf("%s count", tag), 32'(q.size()), nexp);
      for (int j = 0; j < q.size() && j < int'(nexp); j++) begin
         if (j + 1 < rise_q.size())
            chk($sformatf("%s[%0d] cycle", tag, j), q[j].cyc, rise_q[j+1] + 3);
         chk($sformatf("%s[%0d] period", tag, j), 32'(q[j].period), (j % 2 == 0) ? p0 : p1);
         chk($sformatf("%s[%0d] high", tag, j), 32'(q[j].high), h);
         chk($sformatf("%s[%0d] locked", tag, j), 32'(q[j].locked),
             (int'(lock_from) <= j) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic clear_logs();
      va_q.delete();
      vb_q.delete();
      rise_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      tset_cyc  = 0;
      tclr_cyc  = 0;
      tout_prev = 1'b0;
      sig       = 1'b0;
      rst_n     = 1'b0;
      step(3);

      // Reset state
      chk("rst period",  32'(if_a.period), 0);
      chk("rst high",    32'(if_a.high_time), 0);
      chk("rst valid",   32'(if_a.valid), 0);
      chk("rst timeout", 32'(if_a.timeout), 0);
      chk("rst locked",  32'(if_b.locked), 0);

      // Signal held low from reset: timeout after TMO cycles in IDLE
      rst_n = 1'b1;
      t0    = cyc;
      step(105);
      chk("idle timeout cycle", tset_cyc - t0, TMO);
      chk("idle timeout level", 32'(if_a.timeout), 1);
      chk("idle no valid", 32'(va_q.size()), 0);

      // P=10 H=5, five periods, then stop
      clear_logs();
      wave(10, 5, 5);
      step(110);
      check_phase("p10h5 A", va_q, 10, 10, 5, 4, 1);
      check_phase("p10h5 B", vb_q, 10, 10, 5, 4, 1);
      chk("recover timeout clear", tclr_cyc - rise_q[0], 3);
      chk("stop timeout set", tset_cyc - rise_q[4], TMO + 2);
      chk("stop timeout level", 32'(if_a.timeout), 1);
      chk("stop locked", 32'(if_a.locked), 0);
      chk("stop period hold", 32'(if_a.period), 10);
      chk("stop high hold", 32'(if_a.high_time), 5);

      // P=10 H=3
      clear_logs();
      wave(10, 3, 4);
      step(110);
      check_phase("p10h3 A", va_q, 10, 10, 3, 3, 1);

      // Alternating 10/16: only the tolerance-6 instance locks
      clear_logs();
      repeat (3) begin
         wave(10, 5, 1);
         wave(16, 5, 1);
      end
      step(120);
      check_phase("alt tol4", va_q, 10, 16, 5, 5, 99);
      check_phase("alt tol6", vb_q, 10, 16, 5, 5, 1);

      // Reset asserted mid-period
      clear_logs();
      wave(10, 5, 2);
      sig = 1'b1;
      step(5);
      chk("pre-reset locked", 32'(if_a.locked), 1);
      chk("pre-reset period", 32'(if_a.period), 10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst period",  32'(if_a.period), 0);
      chk("async rst high",    32'(if_a.high_time), 0);
      chk("async rst locked",  32'(if_a.locked), 0);
      chk("async rst valid",   32'(if_a.valid), 0);
      chk("async rst timeout", 32'(if_a.timeout), 0);
      sig = 1'b0;
      step(2);
      rst_n = 1'b1;
      clear_logs();
      wave(10, 5, 3);
      step(110);
      check_phase("post-reset A", va_q, 10, 10, 5, 2, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
